fetch_ctrl: RTL and testbench

Program-fetch sequencer for the 9-bit instruction memory. It owns the program counter, drives the memory address, and registers each returned instruction into a one-entry valid/ready output stage toward decode. It also handles branch redirects, halt and restart. It sits between the instruction memory (combinational read, 10-bit address) and the decode stage.

---
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - program-fetch sequencer with one-entry valid/ready output stage
module fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 9,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_en,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt_req,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    handshake;

    assign handshake = valid_q && instr_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = done_q;
        cnt_d    = cnt_q;

        // Counting is independent of the state decisions below.
        if (handshake && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (branch_en) begin
                    // Flush the fetched-ahead instruction; target loads next cycle.
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (!valid_q || instr_ready) begin
                    instr_d  = imem_instr;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 1'b1;
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= START_ADDR;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized self-checking bench for fetch_ctrl against a reference model
module tb_fetch_ctrl;

    localparam int AW   = 10;
    localparam int DW   = 9;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic          clk = 1'b0;
    logic          reset, start, instr_ready, branch_en, halt_req;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] imem_addr, pc_out;
    logic [DW-1:0] imem_instr, instr_out;
    logic          instr_valid, done;
    logic [CW-1:0] fetch_count;

    logic [DW-1:0] mem [1024];

    int tests  = 0;
    int failed = 0;

    int          m_mode;
    int          m_pc, m_opc, m_oin, m_cnt;
    bit          m_valid, m_done;

    assign imem_instr = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .START_ADDR('0),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .done         (done),
        .fetch_count  (fetch_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Spec-level model: the output stage is a single slot holding (pc, word).
    task automatic model_step();
        if (reset) begin
            m_mode = M_IDLE; m_pc = 0; m_opc = 0; m_oin = 0;
            m_valid = 0; m_done = 0; m_cnt = 0;
            return;
        end
        if (m_valid && instr_ready && m_cnt < CMAX) m_cnt++;
        if (m_mode == M_IDLE) begin
            if (start) begin m_mode = M_RUN; m_pc = 0; end
        end else if (m_mode == M_HALT) begin
            if (start) begin m_mode = M_RUN; m_pc = 0; m_done = 0; end
        end else begin
            if (halt_req) begin
                m_mode = M_HALT; m_valid = 0; m_done = 1;
            end else if (branch_en) begin
                m_pc = int'(branch_target); m_valid = 0;
            end else if (!m_valid || instr_ready) begin
                m_opc = m_pc; m_oin = int'(mem[m_pc]); m_valid = 1;
                m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    task automatic compare_all();
        check("imem_addr",   int'(imem_addr),   m_pc);
        check("instr_valid", int'(instr_valid), int'(m_valid));
        check("pc_out",      int'(pc_out),      m_opc);
        check("instr_out",   int'(instr_out),   m_oin);
        check("done",        int'(done),        int'(m_done));
        check("fetch_count", int'(fetch_count), m_cnt);
    endtask

    // Called at a negedge; inputs applied now are seen at the next posedge.
    task automatic tick(input bit st, input bit rdy, input bit br, input int tgt,
                        input bit hl, input bit rst);
        start = st; instr_ready = rdy; branch_en = br;
        branch_target = AW'(tgt); halt_req = hl; reset = rst;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until_pc(input int target);
        int n = 0;
        while (!(m_valid && m_opc == target) && n < 2000) begin
            tick(0, 1, 0, 0, 0, 0);
            n++;
        end
        check("reach_pc_timeout", int'(n < 2000), 1);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = DW'(k);
        start = 0; instr_ready = 0; branch_en = 0; branch_target = '0;
        halt_req = 0; reset = 1;
        m_mode = M_IDLE; m_pc = 0; m_opc = 0; m_oin = 0;
        m_valid = 0; m_done = 0; m_cnt = 0;
        @(negedge clk);

        // Reset state and basic stream: valid rises two edges after start
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        check("first_valid_after_one_edge", int'(instr_valid), 0);
        tick(0, 1, 0, 0, 0, 0);
        check("first_valid_after_two_edges", int'(instr_valid), 1);
        check("first_pc_out", int'(pc_out), 0);
        for (int i = 0; i < 8; i++) tick(0, 1, 0, 0, 0, 0);

        // Backpressure holding pc_out=5
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0);
        run_until_pc(5);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0);
        check("stall_pc_out", int'(pc_out), 5);
        check("stall_pc", int'(imem_addr), 6);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0, 0);

        // Branch accepted at pc_out=10
        run_until_pc(10);
        tick(0, 1, 1, 'h200, 0, 0);
        check("branch_flush", int'(instr_valid), 0);
        tick(0, 1, 0, 0, 0, 0);
        check("branch_target_pc_out", int'(pc_out), 'h200);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0, 0);

        // Halt wins over branch; restart from START_ADDR
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0);
        run_until_pc(20);
        tick(0, 1, 1, 'h300, 1, 0);
        check("halt_done", int'(done), 1);
        tick(0, 1, 1, 'h100, 1, 0);
        tick(1, 1, 0, 0, 0, 0);
        check("restart_done_clear", int'(done), 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0, 0);

        // Wrap 1022, 1023, 0, 1
        tick(0, 1, 1, 1022, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0, 0);

        // Reset mid-run, then idle without start
        tick(0, 1, 0, 0, 0, 1);
        check("midrun_reset_valid", int'(instr_valid), 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0, 0);

        // Random phase with scrambled memory; long runs reach counter saturation
        for (int k = 0; k < 1024; k++) mem[k] = DW'($urandom);
        tick(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(15) == 0), ($urandom_range(3) != 0),
                 ($urandom_range(15) == 0), int'($urandom_range(1023)),
                 ($urandom_range(47) == 0), ($urandom_range(399) == 0));
            if (m_mode != M_RUN && $urandom_range(3) == 0)
                tick(1, 1, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
